hilo_seq: RTL and testbench
===========================

Name: hilo_seq

Overview:
Sequencer and HI/LO register file downstream of the iterative Booth multiplier and divider in the multi-cycle MIPS datapath. Accepts MULT/DIV/MTHI/MTLO commands from the control unit and launches the matching arithmetic unit. It waits for that unit's done, then commits its 64-bit result into the architectural HI/LO registers. Provides busy for control-unit stalls and HI/LO values for MFHI/MFLO.

Parameters:
TIMEOUT, 40, max cycles in a RUN state before abort (must exceed the 33-cycle multiplier latency)
CNT_W, 6, width of the cycle counter; must satisfy 2^CNT_W > TIMEOUT

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
start  in  1  command valid, sampled only in IDLE
op  in  2  00 MULT, 01 DIV, 10 MTHI, 11 MTLO
rs_val  in  32  operand A / MTHI-MTLO data
rt_val  in  32  operand B
mult_start  out  1  one-cycle launch pulse to multiplier
div_start  out  1  one-cycle launch pulse to divider
opnd_a  out  32  latched operand A, held stable while busy
opnd_b  out  32  latched operand B, held stable while busy
mult_done  in  1  multiplier result valid
mult_hi  in  32  multiplier product high word
mult_lo  in  32  multiplier product low word
div_done  in  1  divider result valid
div_rem  in  32  divider remainder
div_quo  in  32  divider quotient
hi  out  32  architectural HI
lo  out  32  architectural LO
busy  out  1  high while in RUN_MULT/RUN_DIV
done  out  1  one-cycle pulse on any command completion
div_zero  out  1  one-cycle pulse, DIV with rt_val==0
timeout  out  1  one-cycle pulse, unit failed to finish

Behaviour:
- Interface: reset reset, asynchronous, active-high; clock clock.
- Reset values: all outputs 0, state IDLE, counter 0. Reset mid-operation aborts immediately; HI/LO are cleared.
- States: IDLE, RUN_MULT, RUN_DIV. All outputs are registered.
- IDLE, start=1, op=MTHI: hi<=rs_val at the edge; done=1 the following cycle; busy stays 0.
- IDLE, start=1, op=MTLO: same as MTHI, writing lo instead.
- IDLE, start=1, op=MULT: opnd_a<=rs_val, opnd_b<=rt_val; mult_start=1 for exactly one cycle; busy=1; counter<=0; go to RUN_MULT.
- IDLE, start=1, op=DIV, rt_val!=0: as MULT but pulses div_start and goes to RUN_DIV.
- IDLE, start=1, op=DIV, rt_val==0: div_zero=1 and done=1 for one cycle; HI/LO unchanged; stay in IDLE; no div_start.
- RUN_MULT, per cycle: counter increments. When mult_done is sampled 1: hi<=mult_hi, lo<=mult_lo, busy<=0, done=1 for one cycle, go to IDLE.
- RUN_DIV: same as RUN_MULT, with hi<=div_rem and lo<=div_quo.
- Timeout: if counter reaches TIMEOUT-1 without the unit's done, pulse timeout=1 (done stays 0), leave HI/LO unchanged, go to IDLE.
- start while busy is ignored; the control unit stalls on busy. done from the wrong unit (div_done in RUN_MULT, etc.) is ignored.
- done pulse and a new start in the same IDLE cycle: the new start is accepted normally.
- hi/lo are visible combinationally-stable from the cycle after commit. No read-during-write bypass.

Decomposition:
- Shared package hilo_pkg holds: op encodings OP_MULT/OP_DIV/OP_MTHI/OP_MTLO, state encodings, and TIMEOUT default.
- No sub-module. An optional sub-module is hilo_regs (HI/LO registers with two write sources); the FSM and counter stay in hilo_seq.

Test Plan:
- MULT rs=8, rt=5; model multiplier asserts done 33 cycles after mult_start -> mult_start single pulse, busy high 34 cycles, then hi=0x00000000, lo=0x00000028, done pulse.
- MULT rs=-3, rt=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; start pulses issued during busy produce no second mult_start.
- DIV rs=7, rt=0 -> div_zero and done pulse next cycle, no div_start, hi/lo keep prior values. Then DIV rs=7, rt=2 with model done -> hi=1, lo=3.
- MTHI rs=0x1234 then MTLO rs=0xABCD on consecutive cycles -> hi=0x1234, lo=0xABCD, two done pulses, busy never asserted.
- MULT with a model unit that never asserts done -> timeout pulse exactly TIMEOUT cycles after mult_start; hi/lo unchanged; back in IDLE.
- Reset asserted 10 cycles into MULT -> busy, hi, lo and all pulse outputs go to 0 immediately; the next MULT completes normally.

Source files
------------

// File: rtl/hilo_pkg.sv
// HI/LO sequencer shared types.
// Op and state encodings plus defaults.
package hilo_pkg;

  typedef enum logic [1:0] {
    OP_MULT = 2'b00,
    OP_DIV  = 2'b01,
    OP_MTHI = 2'b10,
    OP_MTLO = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    RUN_MULT = 2'b01,
    RUN_DIV  = 2'b10
  } state_e;

  localparam int TIMEOUT_DEF = 40;
  localparam int CNT_W_DEF   = 6;

endpackage

// File: rtl/hilo_seq.sv
// HI/LO sequencer: launches mul/div units,
// commits results, handles MTHI/MTLO.
module hilo_seq
  import hilo_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        mult_start,
  output logic        div_start,
  output logic [31:0] opnd_a,
  output logic [31:0] opnd_b,
  input  logic        mult_done,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  input  logic        div_done,
  input  logic [31:0] div_rem,
  input  logic [31:0] div_quo,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic        timeout
);

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(TIMEOUT - 1);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  op_e              op_q;

  assign op_q = op_e'(op);

  // FSM, counter, HI/LO and all pulse outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      mult_start <= 1'b0;
      div_start  <= 1'b0;
      opnd_a     <= '0;
      opnd_b     <= '0;
      hi         <= '0;
      lo         <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      div_zero   <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      mult_start <= 1'b0;
      div_start  <= 1'b0;
      done       <= 1'b0;
      div_zero   <= 1'b0;
      timeout    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            unique case (op_q)
              OP_MTHI: begin
                hi   <= rs_val;
                done <= 1'b1;
              end
              OP_MTLO: begin
                lo   <= rs_val;
                done <= 1'b1;
              end
              OP_MULT: begin
                opnd_a     <= rs_val;
                opnd_b     <= rt_val;
                mult_start <= 1'b1;
                busy       <= 1'b1;
                cnt        <= '0;
                state      <= RUN_MULT;
              end
              OP_DIV: begin
                if (rt_val == '0) begin
                  div_zero <= 1'b1;
                  done     <= 1'b1;
                end else begin
                  opnd_a    <= rs_val;
                  opnd_b    <= rt_val;
                  div_start <= 1'b1;
                  busy      <= 1'b1;
                  cnt       <= '0;
                  state     <= RUN_DIV;
                end
              end
            endcase
          end
        end
        RUN_MULT: begin
          cnt <= cnt + 1'b1;
          if (mult_done) begin
            hi    <= mult_hi;
            lo    <= mult_lo;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end else if (cnt == CNT_LAST) begin
            busy    <= 1'b0;
            timeout <= 1'b1;
            state   <= IDLE;
          end
        end
        RUN_DIV: begin
          cnt <= cnt + 1'b1;
          if (div_done) begin
            hi    <= div_rem;
            lo    <= div_quo;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end else if (cnt == CNT_LAST) begin
            busy    <= 1'b0;
            timeout <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_seq.sv
// Directed bench for hilo_seq with
// behavioural multiplier/divider models.
module tb_hilo_seq;
  import hilo_pkg::*;

  localparam int MLAT = 33;
  localparam int DLAT = 10;
  localparam int TO   = 40;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        mult_start, div_start;
  logic [31:0] opnd_a, opnd_b;
  logic        mult_done = 1'b0;
  logic [31:0] mult_hi = '0, mult_lo = '0;
  logic        div_done = 1'b0;
  logic [31:0] div_rem = '0, div_quo = '0;
  logic [31:0] hi, lo;
  logic        busy, done, div_zero, timeout;

  logic        mult_never = 1'b0;
  int          m_cnt, d_cnt;
  logic        m_run, d_run;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  hilo_seq #(.TIMEOUT(TO), .CNT_W(6)) dut (
    .clock(clock), .reset(reset),
    .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val),
    .mult_start(mult_start),
    .div_start(div_start),
    .opnd_a(opnd_a), .opnd_b(opnd_b),
    .mult_done(mult_done),
    .mult_hi(mult_hi), .mult_lo(mult_lo),
    .div_done(div_done),
    .div_rem(div_rem), .div_quo(div_quo),
    .hi(hi), .lo(lo), .busy(busy),
    .done(done), .div_zero(div_zero),
    .timeout(timeout)
  );

  // Multiplier model: done MLAT cycles after launch
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_run <= 1'b0; m_cnt <= 0;
      mult_done <= 1'b0;
    end else begin
      mult_done <= 1'b0;
      if (mult_start) begin
        m_run <= !mult_never;
        m_cnt <= 1;
        {mult_hi, mult_lo} <=
          $signed(opnd_a) * $signed(opnd_b);
      end else if (m_run) begin
        m_cnt <= m_cnt + 1;
        if (m_cnt == MLAT - 1) begin
          mult_done <= 1'b1;
          m_run <= 1'b0;
        end
      end
    end
  end

  // Divider model: done DLAT cycles after launch
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      d_run <= 1'b0; d_cnt <= 0;
      div_done <= 1'b0;
    end else begin
      div_done <= 1'b0;
      if (div_start) begin
        d_run <= 1'b1;
        d_cnt <= 1;
        div_quo <= $signed(opnd_a) / $signed(opnd_b);
        div_rem <= $signed(opnd_a) % $signed(opnd_b);
      end else if (d_run) begin
        d_cnt <= d_cnt + 1;
        if (d_cnt == DLAT - 1) begin
          div_done <= 1'b1;
          d_run <= 1'b0;
        end
      end
    end
  end

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h",
               nm, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] e_hi;
    logic [31:0] e_lo;
    logic        e_dz;
    int          e_busy;
    int          e_ms;
    int          e_ds;
  } vec_t;

  vec_t vt[8];

  // Issue one command, track pulses until done
  task automatic run_vec(input vec_t v, input int idx);
    int bc = 0, ms = 0, ds = 0, k = 0;
    logic gd = 1'b0, gdz = 1'b0, gto = 1'b0;
    @(negedge clock);
    start = 1'b1; op = v.op;
    rs_val = v.rs; rt_val = v.rt;
    @(negedge clock);
    while (k < 100) begin
      if (mult_start) ms++;
      if (div_start) ds++;
      if (busy) bc++;
      if (div_zero) gdz = 1'b1;
      if (timeout) gto = 1'b1;
      if (done) gd = 1'b1;
      if (done || timeout) break;
      start = busy & k[0];
      k++;
      @(negedge clock);
    end
    start = 1'b0;
    if (k >= 100)
      check($sformatf("v%0d wait", idx), 1, 0);
    check($sformatf("v%0d done", idx), 32'(gd), 1);
    check($sformatf("v%0d tmo", idx), 32'(gto), 0);
    check($sformatf("v%0d dz", idx),
          32'(gdz), 32'(v.e_dz));
    check($sformatf("v%0d hi", idx), hi, v.e_hi);
    check($sformatf("v%0d lo", idx), lo, v.e_lo);
    check($sformatf("v%0d busy_n", idx),
          bc, v.e_busy);
    check($sformatf("v%0d mstart_n", idx),
          ms, v.e_ms);
    check($sformatf("v%0d dstart_n", idx),
          ds, v.e_ds);
    @(negedge clock);
    check($sformatf("v%0d done_1cyc", idx),
          32'(done), 0);
  endtask

  initial begin
    int k;
    logic [31:0] sh, sl;
    vt[0] = '{OP_MULT, 32'd8, 32'd5,
              32'h0, 32'h28, 0, 34, 1, 0};
    vt[1] = '{OP_MULT, 32'hFFFFFFFD, 32'd7,
              32'hFFFFFFFF, 32'hFFFFFFEB, 0, 34, 1, 0};
    vt[2] = '{OP_DIV, 32'd7, 32'd0,
              32'hFFFFFFFF, 32'hFFFFFFEB, 1, 0, 0, 0};
    vt[3] = '{OP_DIV, 32'd7, 32'd2,
              32'h1, 32'h3, 0, 11, 0, 1};
    vt[4] = '{OP_MTHI, 32'h1234, 32'h0,
              32'h1234, 32'h3, 0, 0, 0, 0};
    vt[5] = '{OP_MTLO, 32'hABCD, 32'h0,
              32'h1234, 32'hABCD, 0, 0, 0, 0};
    vt[6] = '{OP_DIV, 32'hFFFFFFEC, 32'd3,
              32'hFFFFFFFE, 32'hFFFFFFFA, 0, 11, 0, 1};
    vt[7] = '{OP_MULT, 32'h10000, 32'h10000,
              32'h1, 32'h0, 0, 34, 1, 0};

    repeat (3) @(negedge clock);
    check("rst hi", hi, 0);
    check("rst lo", lo, 0);
    check("rst flags",
          {26'd0, busy, done, div_zero, timeout,
           mult_start, div_start}, 0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vt[i], i);

    // back-to-back MTHI/MTLO
    @(negedge clock);
    start = 1'b1; op = OP_MTHI; rs_val = 32'h55;
    @(negedge clock);
    check("b2b done1", 32'(done), 1);
    check("b2b hi", hi, 32'h55);
    op = OP_MTLO; rs_val = 32'h66;
    @(negedge clock);
    start = 1'b0;
    check("b2b done2", 32'(done), 1);
    check("b2b lo", lo, 32'h66);
    check("b2b busy", 32'(busy), 0);

    // timeout: multiplier never finishes
    mult_never = 1'b1;
    sh = hi; sl = lo;
    @(negedge clock);
    start = 1'b1; op = OP_MULT;
    rs_val = 32'd9; rt_val = 32'd9;
    @(negedge clock);
    start = 1'b0;
    check("to mstart", 32'(mult_start), 1);
    k = 0;
    while (!timeout && k < 100) begin
      if (done) check("to spurious done", 1, 0);
      k++;
      @(negedge clock);
    end
    check("to latency", k, TO);
    check("to done", 32'(done), 0);
    check("to hi", hi, sh);
    check("to lo", lo, sl);
    check("to busy", 32'(busy), 0);
    mult_never = 1'b0;

    // async reset mid-multiply
    @(negedge clock);
    start = 1'b1; op = OP_MULT;
    rs_val = 32'd3; rt_val = 32'd4;
    @(negedge clock);
    start = 1'b0;
    repeat (10) @(negedge clock);
    check("pre-rst busy", 32'(busy), 1);
    #2 reset = 1'b1;
    #1;
    check("arst busy", 32'(busy), 0);
    check("arst hi", hi, 0);
    check("arst lo", lo, 0);
    check("arst pulses",
          {28'd0, done, div_zero, timeout,
           mult_start}, 0);
    @(negedge clock);
    reset = 1'b0;
    run_vec(vt[0], 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
